// File: rtl/otp_auth_pkg.sv
// Shared types and constants for the one-time-password authenticator.
package otp_auth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_CHECK    = 3'd2,
    ST_UNLOCKED = 3'd3,
    ST_LOCKED   = 3'd4,
    ST_EXPIRED  = 3'd5
  } otp_state_e;

  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_ACE1;

  // Maximal-length Galois feedback masks (right-shifting form) for 8..32 bits.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       lfsr_taps = 32'h0000_00B8;
      9:       lfsr_taps = 32'h0000_0110;
      10:      lfsr_taps = 32'h0000_0240;
      11:      lfsr_taps = 32'h0000_0500;
      12:      lfsr_taps = 32'h0000_0E08;
      13:      lfsr_taps = 32'h0000_1C80;
      14:      lfsr_taps = 32'h0000_3802;
      15:      lfsr_taps = 32'h0000_6000;
      16:      lfsr_taps = 32'h0000_B400;
      17:      lfsr_taps = 32'h0001_2000;
      18:      lfsr_taps = 32'h0002_0400;
      19:      lfsr_taps = 32'h0007_2000;
      20:      lfsr_taps = 32'h0009_0000;
      21:      lfsr_taps = 32'h0014_0000;
      22:      lfsr_taps = 32'h0030_0000;
      23:      lfsr_taps = 32'h0042_0000;
      24:      lfsr_taps = 32'h00E1_0000;
      25:      lfsr_taps = 32'h0120_0000;
      26:      lfsr_taps = 32'h0200_0023;
      27:      lfsr_taps = 32'h0400_0013;
      28:      lfsr_taps = 32'h0900_0000;
      29:      lfsr_taps = 32'h1400_0000;
      30:      lfsr_taps = 32'h2000_0029;
      31:      lfsr_taps = 32'h4800_0000;
      32:      lfsr_taps = 32'h8020_0003;
      default: lfsr_taps = 32'h0000_B400;
    endcase
  endfunction

endpackage

// File: rtl/otp_auth_core_lfsr.sv
// Free-running Galois LFSR supplying the random source for new OTPs.
module otp_lfsr_n
  import otp_auth_pkg::*;
#(
  parameter int unsigned        WIDTH = 16,
  parameter logic [WIDTH-1:0]   SEED  = WIDTH'(LFSR_DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [WIDTH-1:0] o_value
);

  localparam logic [31:0]      TAPS_FULL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];
  // A zero seed would lock the register at zero forever, so it is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_NZ   = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] r_state;

  // Advance one step every cycle, folding the taps in whenever a one shifts out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= SEED_NZ;
    else          r_state <= r_state[0] ? ((r_state >> 1) ^ TAPS) : (r_state >> 1);
  end

  assign o_value = r_state;

endmodule

// File: rtl/otp_auth_core.sv
// OTP authenticator: generates a code, collects entered digits, compares,
// counts failures, locks out for a while and expires stale codes.
module otp_auth_core
  import otp_auth_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned DIGIT_W       = 4,
  parameter int unsigned MAX_ATTEMPTS  = 3,
  parameter int unsigned EXPIRE_CYCLES = 50_000_000,
  parameter int unsigned LOCK_CYCLES   = 500_000_000,
  parameter int unsigned UNLOCK_CYCLES = 100_000_000,
  parameter logic [31:0] LFSR_SEED     = LFSR_DEFAULT_SEED
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [DIGIT_W-1:0]             user_in,
  input  logic                           otp_latch,
  input  logic                           user_latch,
  output logic [DIGITS*DIGIT_W-1:0]      otp,
  output logic [DIGITS*DIGIT_W-1:0]      user_otp,
  output logic [$clog2(DIGITS+1)-1:0]    digit_cnt,
  output logic [3:0]                     wrng_atmpt,
  output logic                           unlock,
  output logic                           lock,
  output logic                           expired,
  output logic [2:0]                     state
);

  localparam int unsigned W  = DIGITS * DIGIT_W;
  localparam int unsigned CW = $clog2(DIGITS + 1);

  logic [W-1:0]  w_lfsr;
  logic          r_otpPrev, r_userPrev, r_otpPulse, r_userPulse;

  otp_state_e    r_state, w_nextState;
  logic [W-1:0]  r_otp, w_nextOtp, r_userOtp, w_nextUser;
  logic [CW-1:0] r_digitCnt, w_nextCnt, w_cntInc;
  logic [3:0]    r_wrong, w_nextWrong, w_wrongInc;
  logic [31:0]   r_expTimer, w_nextExpTimer, r_holdTimer, w_nextHoldTimer;
  logic          r_unlock, r_lock, r_expired, w_newSession;

  otp_lfsr_n #(
    .WIDTH (W),
    .SEED  (LFSR_SEED[W-1:0])
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .o_value (w_lfsr)
  );

  assign w_cntInc   = r_digitCnt + CW'(1);
  assign w_wrongInc = r_wrong + 4'd1;

  // Registered rising-edge detectors so each button press yields one clean pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_otpPrev   <= 1'b0;
      r_userPrev  <= 1'b0;
      r_otpPulse  <= 1'b0;
      r_userPulse <= 1'b0;
    end else begin
      r_otpPrev   <= otp_latch;
      r_userPrev  <= user_latch;
      r_otpPulse  <= otp_latch & ~r_otpPrev;
      r_userPulse <= user_latch & ~r_userPrev;
    end
  end

  // Next-state logic; in ENTRY expiry beats a new request, which beats a digit.
  always_comb begin
    w_nextState     = r_state;
    w_nextOtp       = r_otp;
    w_nextUser      = r_userOtp;
    w_nextCnt       = r_digitCnt;
    w_nextWrong     = r_wrong;
    w_nextExpTimer  = r_expTimer;
    w_nextHoldTimer = r_holdTimer;
    w_newSession    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_otpPulse) w_newSession = 1'b1;
      end
      ST_ENTRY: begin
        if (r_expTimer == 32'(EXPIRE_CYCLES - 1)) begin
          w_nextState = ST_EXPIRED;
        end else begin
          w_nextExpTimer = r_expTimer + 32'd1;
          if (r_otpPulse) begin
            w_newSession = 1'b1;
          end else if (r_userPulse) begin
            w_nextUser = {r_userOtp[W-DIGIT_W-1:0], user_in};
            w_nextCnt  = w_cntInc;
            if (w_cntInc == CW'(DIGITS)) w_nextState = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (r_userOtp == r_otp) begin
          w_nextState     = ST_UNLOCKED;
          w_nextWrong     = 4'd0;
          w_nextHoldTimer = 32'd0;
        end else begin
          w_nextWrong = w_wrongInc;
          w_nextUser  = '0;
          w_nextCnt   = '0;
          if (w_wrongInc == 4'(MAX_ATTEMPTS)) begin
            w_nextState     = ST_LOCKED;
            w_nextHoldTimer = 32'd0;
          end else begin
            w_nextState = ST_ENTRY;
          end
        end
      end
      ST_UNLOCKED: begin
        if (r_otpPulse) begin
          w_newSession = 1'b1;
        end else if (r_holdTimer == 32'(UNLOCK_CYCLES - 1)) begin
          w_nextState = ST_IDLE;
        end else begin
          w_nextHoldTimer = r_holdTimer + 32'd1;
        end
      end
      ST_LOCKED: begin
        if (r_holdTimer == 32'(LOCK_CYCLES - 1)) begin
          w_nextState = ST_IDLE;
          w_nextWrong = 4'd0;
        end else begin
          w_nextHoldTimer = r_holdTimer + 32'd1;
        end
      end
      ST_EXPIRED: begin
        if (r_otpPulse) w_newSession = 1'b1;
      end
      default: w_nextState = ST_IDLE;
    endcase
    if (w_newSession) begin
      w_nextState    = ST_ENTRY;
      w_nextOtp      = w_lfsr;
      w_nextUser     = '0;
      w_nextCnt      = '0;
      w_nextExpTimer = 32'd0;
    end
  end

  // State and datapath registers; indicator flags decode the upcoming state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_otp       <= '0;
      r_userOtp   <= '0;
      r_digitCnt  <= '0;
      r_wrong     <= 4'd0;
      r_expTimer  <= 32'd0;
      r_holdTimer <= 32'd0;
      r_unlock    <= 1'b0;
      r_lock      <= 1'b0;
      r_expired   <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_otp       <= w_nextOtp;
      r_userOtp   <= w_nextUser;
      r_digitCnt  <= w_nextCnt;
      r_wrong     <= w_nextWrong;
      r_expTimer  <= w_nextExpTimer;
      r_holdTimer <= w_nextHoldTimer;
      r_unlock    <= (w_nextState == ST_UNLOCKED);
      r_lock      <= (w_nextState == ST_LOCKED);
      r_expired   <= (w_nextState == ST_EXPIRED);
    end
  end

  assign otp        = r_otp;
  assign user_otp   = r_userOtp;
  assign digit_cnt  = r_digitCnt;
  assign wrng_atmpt = r_wrong;
  assign unlock     = r_unlock;
  assign lock       = r_lock;
  assign expired    = r_expired;
  assign state      = r_state;

endmodule

// File: tb/tb_otp_auth_core.sv
// Self-checking bench for otp_auth_core using a small scoreboard queue.
module tb_otp_auth_core;

  // Small timer values keep the whole session flow to a few hundred cycles.
  localparam int DIGITS = 4;
  localparam int DIGIT_W = 4;

  localparam int S_IDLE = 0, S_ENTRY = 1, S_CHECK = 2, S_UNLOCK = 3, S_LOCK = 4, S_EXP = 5;
  localparam int SEL_OTP = 0, SEL_USER = 1, SEL_CNT = 2, SEL_WRONG = 3;
  localparam int SEL_UNLOCK = 4, SEL_LOCK = 5, SEL_EXPIRED = 6, SEL_STATE = 7;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  user_in;
  logic        otp_latch, user_latch;
  logic [15:0] otp, user_otp;
  logic [2:0]  digit_cnt;
  logic [3:0]  wrng_atmpt;
  logic        unlock, lock, expired;
  logic [2:0]  state;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sbQ[$];
  int          checks = 0;
  int          failures = 0;
  int          cycleCnt = 0;
  logic [15:0] mdlLfsr;
  logic [15:0] expOtp, cap;
  int          capCyc, hiCnt, lockCnt;

  otp_auth_core #(
    .DIGITS        (DIGITS),
    .DIGIT_W       (DIGIT_W),
    .MAX_ATTEMPTS  (3),
    .EXPIRE_CYCLES (64),
    .LOCK_CYCLES   (32),
    .UNLOCK_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .user_in    (user_in),
    .otp_latch  (otp_latch),
    .user_latch (user_latch),
    .otp        (otp),
    .user_otp   (user_otp),
    .digit_cnt  (digit_cnt),
    .wrng_atmpt (wrng_atmpt),
    .unlock     (unlock),
    .lock       (lock),
    .expired    (expired),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Edge counter used to measure latencies in whole clock cycles.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Reference 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, seed ACE1.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) mdlLfsr <= 16'hACE1;
    else          mdlLfsr <= mdlLfsr[0] ? ((mdlLfsr >> 1) ^ 16'hB400) : (mdlLfsr >> 1);
  end

  // Hard stop in case something wedges the flow entirely.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pick the DUT output that a scoreboard entry refers to.
  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_OTP:     observe = {16'h0, otp};
      SEL_USER:    observe = {16'h0, user_otp};
      SEL_CNT:     observe = {29'h0, digit_cnt};
      SEL_WRONG:   observe = {28'h0, wrng_atmpt};
      SEL_UNLOCK:  observe = {31'h0, unlock};
      SEL_LOCK:    observe = {31'h0, lock};
      SEL_EXPIRED: observe = {31'h0, expired};
      SEL_STATE:   observe = {29'h0, state};
      default:     observe = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic pushExp(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sbQ.push_back(e);
  endtask

  // Drain every pending expectation against what the DUT shows right now.
  task automatic checkScoreboard();
    exp_t e;
    while (sbQ.size() != 0) begin
      e = sbQ.pop_front();
      checkOutput(e.tag, observe(e.sel), e.val);
    end
  endtask

  // Raise the requested buttons at a negedge, drop them one cycle later and
  // return at the negedge after the FSM has acted; also reports the LFSR
  // value the FSM will sample when an OTP request lands.
  task automatic applyStimulus(input bit doOtp, input bit doUser, input logic [3:0] digit,
                               output logic [15:0] lfsrAtLatch);
    user_in    = digit;
    otp_latch  = doOtp;
    user_latch = doUser;
    @(posedge clk);
    @(negedge clk);
    lfsrAtLatch = mdlLfsr;
    otp_latch  = 1'b0;
    user_latch = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Key in a full four-digit code, most significant digit first.
  task automatic enterCode(input logic [15:0] code);
    logic [15:0] dummy;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, code[15-4*i -: 4], dummy);
  endtask

  initial begin
    reset_n    = 1'b0;
    otp_latch  = 1'b0;
    user_latch = 1'b0;
    user_in    = 4'h0;
    #1;
    // Reset values.
    pushExp("rst_otp", SEL_OTP, 0);
    pushExp("rst_user", SEL_USER, 0);
    pushExp("rst_cnt", SEL_CNT, 0);
    pushExp("rst_wrong", SEL_WRONG, 0);
    pushExp("rst_unlock", SEL_UNLOCK, 0);
    pushExp("rst_lock", SEL_LOCK, 0);
    pushExp("rst_expired", SEL_EXPIRED, 0);
    pushExp("rst_state", SEL_STATE, S_IDLE);
    checkScoreboard();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Correct code: OTP latched from the LFSR, then unlock for 16 cycles.
    applyStimulus(1'b1, 1'b0, 4'h0, cap);
    expOtp = cap;
    pushExp("t1_otp", SEL_OTP, {16'h0, expOtp});
    pushExp("t1_state", SEL_STATE, S_ENTRY);
    pushExp("t1_cnt0", SEL_CNT, 0);
    checkScoreboard();
    enterCode(expOtp);
    pushExp("t1_user", SEL_USER, {16'h0, expOtp});
    pushExp("t1_cnt4", SEL_CNT, 4);
    pushExp("t1_check", SEL_STATE, S_CHECK);
    checkScoreboard();
    @(negedge clk);
    pushExp("t1_unlock", SEL_UNLOCK, 1);
    pushExp("t1_wrong", SEL_WRONG, 0);
    pushExp("t1_unl_state", SEL_STATE, S_UNLOCK);
    checkScoreboard();
    hiCnt = 0;
    for (int i = 0; i < 40 && unlock; i++) begin
      hiCnt++;
      @(negedge clk);
    end
    checkOutput("t1_unlock_len", hiCnt, 16);
    pushExp("t1_idle", SEL_STATE, S_IDLE);
    checkScoreboard();

    // Three wrong codes lead to a 32-cycle lockout that ignores the buttons.
    applyStimulus(1'b1, 1'b0, 4'h0, cap);
    expOtp = cap;
    pushExp("t2_otp", SEL_OTP, {16'h0, expOtp});
    checkScoreboard();
    for (int a = 1; a <= 3; a++) begin
      enterCode(16'h0000);
      @(negedge clk);
      pushExp("t2_wrong", SEL_WRONG, a);
      if (a < 3) begin
        pushExp("t2_retry_state", SEL_STATE, S_ENTRY);
        pushExp("t2_retry_cnt", SEL_CNT, 0);
      end else begin
        pushExp("t2_lock_state", SEL_STATE, S_LOCK);
        pushExp("t2_lock", SEL_LOCK, 1);
      end
      checkScoreboard();
    end
    lockCnt = 0;
    for (int i = 0; i < 80 && lock; i++) begin
      lockCnt++;
      if (lockCnt < 24) begin
        otp_latch  = lockCnt[0];
        user_latch = ~lockCnt[0];
      end else begin
        otp_latch  = 1'b0;
        user_latch = 1'b0;
      end
      @(negedge clk);
    end
    otp_latch  = 1'b0;
    user_latch = 1'b0;
    checkOutput("t2_lock_len", lockCnt, 32);
    pushExp("t2_idle", SEL_STATE, S_IDLE);
    pushExp("t2_wrong_clr", SEL_WRONG, 0);
    pushExp("t2_otp_kept", SEL_OTP, {16'h0, expOtp});
    pushExp("t2_cnt_kept", SEL_CNT, 0);
    checkScoreboard();

    // Expiry: one wrong try, two digits, then the window runs out.
    applyStimulus(1'b1, 1'b0, 4'h0, cap);
    expOtp = cap;
    capCyc = cycleCnt;
    pushExp("t3_otp", SEL_OTP, {16'h0, expOtp});
    checkScoreboard();
    enterCode(16'h0000);
    @(negedge clk);
    pushExp("t3_wrong", SEL_WRONG, 1);
    pushExp("t3_state", SEL_STATE, S_ENTRY);
    checkScoreboard();
    applyStimulus(1'b0, 1'b1, 4'h5, cap);
    applyStimulus(1'b0, 1'b1, 4'hA, cap);
    pushExp("t3_cnt2", SEL_CNT, 2);
    pushExp("t3_user2", SEL_USER, 32'h005A);
    checkScoreboard();
    for (int i = 0; i < 100 && !expired; i++) @(negedge clk);
    pushExp("t3_expired", SEL_EXPIRED, 1);
    pushExp("t3_exp_state", SEL_STATE, S_EXP);
    checkScoreboard();
    checkOutput("t3_expire_time", cycleCnt - capCyc, 65);
    applyStimulus(1'b0, 1'b1, 4'h7, cap);
    pushExp("t3_ign_cnt", SEL_CNT, 2);
    pushExp("t3_ign_user", SEL_USER, 32'h005A);
    pushExp("t3_ign_state", SEL_STATE, S_EXP);
    checkScoreboard();
    applyStimulus(1'b1, 1'b0, 4'h0, cap);
    expOtp = cap;
    pushExp("t3_new_otp", SEL_OTP, {16'h0, expOtp});
    pushExp("t3_exp_clr", SEL_EXPIRED, 0);
    pushExp("t3_new_cnt", SEL_CNT, 0);
    pushExp("t3_wrong_kept", SEL_WRONG, 1);
    pushExp("t3_new_state", SEL_STATE, S_ENTRY);
    checkScoreboard();

    // Simultaneous request and digit: the digit is dropped, OTP regenerated.
    applyStimulus(1'b0, 1'b1, 4'h3, cap);
    pushExp("t4_cnt1", SEL_CNT, 1);
    pushExp("t4_user1", SEL_USER, 32'h0003);
    checkScoreboard();
    applyStimulus(1'b1, 1'b1, 4'h9, cap);
    expOtp = cap;
    capCyc = cycleCnt;
    pushExp("t4_otp", SEL_OTP, {16'h0, expOtp});
    pushExp("t4_cnt0", SEL_CNT, 0);
    pushExp("t4_user0", SEL_USER, 0);
    pushExp("t4_wrong", SEL_WRONG, 1);
    checkScoreboard();

    // Fourth digit lands on the expiry cycle: expiry wins, no CHECK.
    applyStimulus(1'b0, 1'b1, 4'h1, cap);
    applyStimulus(1'b0, 1'b1, 4'h2, cap);
    applyStimulus(1'b0, 1'b1, 4'h3, cap);
    pushExp("t5_cnt3", SEL_CNT, 3);
    checkScoreboard();
    while (cycleCnt < capCyc + 62) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 4'h4, cap);
    pushExp("t5_state", SEL_STATE, S_EXP);
    pushExp("t5_expired", SEL_EXPIRED, 1);
    pushExp("t5_cnt", SEL_CNT, 3);
    pushExp("t5_user", SEL_USER, 32'h0123);
    pushExp("t5_wrong", SEL_WRONG, 1);
    checkScoreboard();

    // Asynchronous reset in the middle of a lockout.
    applyStimulus(1'b1, 1'b0, 4'h0, cap);
    expOtp = cap;
    pushExp("t6_otp", SEL_OTP, {16'h0, expOtp});
    checkScoreboard();
    for (int a = 2; a <= 3; a++) begin
      enterCode(16'h0000);
      @(negedge clk);
      pushExp("t6_wrong", SEL_WRONG, a);
      checkScoreboard();
    end
    pushExp("t6_lock", SEL_LOCK, 1);
    checkScoreboard();
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    pushExp("t6_lock_clr", SEL_LOCK, 0);
    pushExp("t6_state", SEL_STATE, S_IDLE);
    pushExp("t6_wrong_clr", SEL_WRONG, 0);
    pushExp("t6_otp_clr", SEL_OTP, 0);
    checkScoreboard();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/otp_auth_core.md
# otp_auth_core

Parametrised one-time-password authenticator core: free-running LFSR generates an N-digit OTP on request, user enters digits one at a time, the core compares, counts wrong attempts, applies a timed lockout and expires stale OTPs. Sits between the button/switch inputs and the 7-segment display driver; all outputs feed the display layer directly. Generalises the fixed 4-digit, reset-to-unlock flow with configurable digit count, attempt limit, expiry window and self-releasing lockout.

## Interface
- DIGITS, 4: OTP length in digits; DIGITS*DIGIT_W must be 8..32
- DIGIT_W, 4: bits per digit
- MAX_ATTEMPTS, 3: wrong attempts before lockout (1..15)
- EXPIRE_CYCLES, 50_000_000: cycles an OTP stays valid after generation
- LOCK_CYCLES, 500_000_000: lockout duration
- UNLOCK_CYCLES, 100_000_000: unlock indication duration
- LFSR_SEED, 16'hACE1 (zero-extended or truncated to OTP width): LFSR reset value, must be nonzero
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- user_in  in  DIGIT_W  digit switches
- otp_latch  in  1  level button: request new OTP
- user_latch  in  1  level button: enter one digit
- otp  out  DIGITS*DIGIT_W  latched OTP
- user_otp  out  DIGITS*DIGIT_W  digits entered so far
- digit_cnt  out  $clog2(DIGITS+1)  digits entered
- wrng_atmpt  out  4  wrong-attempt count
- unlock  out  1  match indication
- lock  out  1  lockout active
- expired  out  1  OTP expired
- state  out  3  FSM state, debug

## Operation
- Buttons pass through internal rising-edge detectors (registered previous value; pulse = cur & ~prev, one cycle).
- LFSR: Galois, OTP width, advances every cycle from reset; taps from package function; all-zero state impossible.
- States: IDLE, ENTRY, CHECK, UNLOCKED, LOCKED, EXPIRED.
- IDLE: otp_latch pulse -> otp <= LFSR value, user_otp <= 0, digit_cnt <= 0, expiry timer <= 0, -> ENTRY.
- ENTRY: user_latch pulse -> user_otp <= {user_otp[W-DIGIT_W-1:0], user_in}, digit_cnt++; when digit_cnt reaches DIGITS -> CHECK. otp_latch pulse -> regenerate OTP, clear entry, restart timer, wrng_atmpt kept.
- CHECK (one cycle): user_otp == otp -> UNLOCKED, wrng_atmpt <= 0. Else wrng_atmpt++; new count == MAX_ATTEMPTS -> LOCKED, otherwise -> ENTRY with user_otp, digit_cnt cleared, timer not restarted.
- UNLOCKED: unlock = 1 for UNLOCK_CYCLES then IDLE; otp_latch pulse ends it early and starts a new session (as IDLE).
- LOCKED: lock = 1 for LOCK_CYCLES, all buttons ignored, then IDLE with wrng_atmpt <= 0.
- EXPIRED: entered from ENTRY when timer == EXPIRE_CYCLES-1; expired = 1; user_latch ignored; otp_latch pulse -> new OTP, -> ENTRY, expired <= 0. wrng_atmpt kept.
- Priorities in ENTRY same cycle: expiry > otp_latch > user_latch (digit discarded).
- Buttons ignored in CHECK.

## Timing
- Reset: otp, user_otp, digit_cnt, wrng_atmpt = 0; unlock, lock, expired = 0; state = IDLE; LFSR = LFSR_SEED; edge detector history = 0.
- Button rise at input -> register update 2 cycles later (1 edge detect, 1 FSM).
- Last digit registered cycle N -> CHECK at N+1 -> unlock/lock/wrng_atmpt visible N+2.
- unlock high exactly UNLOCK_CYCLES cycles; lock high exactly LOCK_CYCLES cycles.
- All outputs registered; no combinational input-to-output path.
- Reset mid-session returns immediately to reset values; attempt count not retained.

## Structure
- Package otp_auth_pkg: state enum, lfsr_taps(width) function (maximal-length taps for 8..32), default seed constant.
- Sub-module otp_lfsr_n (parametrised Galois LFSR, width and seed parameters); edge detectors, timers and FSM inline.

## Test plan
Bench parameters DIGITS=4, MAX_ATTEMPTS=3, EXPIRE_CYCLES=64, LOCK_CYCLES=32, UNLOCK_CYCLES=16.
- Reset, otp_latch at known cycle -> otp equals model LFSR value; enter its 4 digits -> unlock high 16 cycles, wrng_atmpt 0, back to IDLE.
- Three wrong entries of 16'h0000 (otp nonzero) -> wrng_atmpt 1,2,3; lock high 32 cycles; buttons ignored; then IDLE, wrng_atmpt 0.
- Enter 2 digits, wait 64 cycles -> expired 1, further user_latch ignored; otp_latch -> new otp, expired 0, digit_cnt 0, wrng_atmpt unchanged.
- otp_latch and user_latch rising same cycle in ENTRY -> digit dropped, digit_cnt 0, otp regenerated.
- Fourth digit and expiry on same cycle -> EXPIRED, no CHECK, wrng_atmpt unchanged.
- reset_n low during LOCKED -> lock 0, state IDLE, wrng_atmpt 0 asynchronously.
